// File: rtl/rgb_row_writer.sv
// rgb_row_writer
//   Assembles a 16-pixel display row from a serial bit stream, then holds the
//   completed row until the consumer acknowledges it. Row addresses run
//   0..ROWS-1 and wrap; FRAME_DONE pulses after the last row of a frame is taken.
//
// Optional feature macro: ROW_PARITY_EN
//   defined   -> ROW_PAR is the registered even parity (XOR) of ROW_DATA
//   undefined -> no parity logic, ROW_PAR tied to 0
//
// Ports
//   CLK        in   system clock, rising edge
//   RST        in   synchronous active-high reset
//   BIT_IN     in   serial pixel bit for column COL
//   BIT_VALID  in   BIT_IN valid this cycle
//   BIT_READY  out  block accepts a bit this cycle (FILL state)
//   COL        out  column the next accepted bit is written to
//   ROW_DATA   out  assembled row, bit k = column k
//   ROW_ADDR   out  row index of ROW_DATA
//   ROW_VALID  out  row complete and stable (HOLD state)
//   ROW_ACK    in   consumer has taken the row (honoured only in HOLD)
//   FRAME_DONE out  one-cycle pulse after row ROWS-1 is acknowledged
//   ROW_PAR    out  parity of ROW_DATA (see macro above)
module rgb_row_writer #(
  parameter int unsigned ROWS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        BIT_IN,
  input  logic        BIT_VALID,
  output logic        BIT_READY,
  output logic [3:0]  COL,
  output logic [15:0] ROW_DATA,
  output logic [3:0]  ROW_ADDR,
  output logic        ROW_VALID,
  input  logic        ROW_ACK,
  output logic        FRAME_DONE,
  output logic        ROW_PAR
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
  localparam logic [3:0] LAST_COL = 4'd15;

  state_t      state_q, state_d;
  logic [3:0]  col_q,   col_d;
  logic [15:0] row_q,   row_d;
  logic [3:0]  addr_q,  addr_d;
  logic        done_q,  done_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FILL;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    unique case (state_q)
      FILL: begin
        if (BIT_VALID) begin
          row_d[col_q] = BIT_IN;
          if (col_q == LAST_COL) begin
            col_d   = '0;
            state_d = HOLD;
          end else begin
            col_d = col_q + 4'd1;
          end
        end
      end
      HOLD: begin
        if (ROW_ACK) begin
          state_d = FILL;
          if (addr_q == LAST_ROW) begin
            addr_d = '0;
            done_d = 1'b1;
          end else begin
            addr_d = addr_q + 4'd1;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Handshake outputs decode straight from the state flop, so they stay registered.
  assign BIT_READY  = (state_q == FILL);
  assign ROW_VALID  = (state_q == HOLD);
  assign COL        = col_q;
  assign ROW_DATA   = row_q;
  assign ROW_ADDR   = addr_q;
  assign FRAME_DONE = done_q;

`ifdef ROW_PARITY_EN
  logic par_q;

  // Parity is taken from the next-row value so it lines up with ROW_DATA.
  always_ff @(posedge CLK) begin
    if (RST) begin
      par_q <= 1'b0;
    end else begin
      par_q <= ^row_d;
    end
  end

  assign ROW_PAR = par_q;
`else
  assign ROW_PAR = 1'b0;
`endif

endmodule

// File: doc/rgb_row_writer.md
RGB_ROW_WRITER -- requirements
Module: rgb_row_writer

Interface
REQ-001 Parameter ROWS, default 16, number of display rows per frame; range 2..16.
REQ-002 CLK  input  1  system clock; all state updates on its rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 BIT_IN  input  1  serial pixel bit for the current column.
REQ-005 BIT_VALID  input  1  BIT_IN holds a valid bit this cycle.
REQ-006 BIT_READY  output  1  block accepts a bit this cycle.
REQ-007 COL  output  4  column index the next accepted bit is written to.
REQ-008 ROW_DATA  output  16  assembled row; bit k = column k, so a 16:1 row mux with SEL=k returns the bit written at column k.
REQ-009 ROW_ADDR  output  4  row index of ROW_DATA.
REQ-010 ROW_VALID  output  1  ROW_DATA/ROW_ADDR complete and stable.
REQ-011 ROW_ACK  input  1  consumer has taken the row.
REQ-012 FRAME_DONE  output  1  one-cycle pulse when row ROWS-1 is acknowledged.
REQ-013 ROW_PAR  output  1  even parity of ROW_DATA (see Configuration).

Function
REQ-014 Two states SHALL exist: FILL (BIT_READY=1, ROW_VALID=0) and HOLD (BIT_READY=0, ROW_VALID=1); all outputs registered.
REQ-015 In FILL, a bit is accepted when BIT_VALID=1 and BIT_READY=1; at that edge ROW_DATA[COL] <= BIT_IN, other ROW_DATA bits unchanged.
REQ-016 On acceptance with COL<15, COL SHALL increment by 1; BIT_VALID=0 leaves all state unchanged.
REQ-017 On acceptance with COL=15, COL SHALL wrap to 0 and state SHALL go to HOLD; ROW_VALID is high the cycle after that edge (latency 1 cycle).
REQ-018 In HOLD, ROW_DATA and ROW_ADDR SHALL not change and BIT_VALID SHALL be ignored (no bit lost: producer holds it since BIT_READY=0).
REQ-019 In HOLD with ROW_ACK=1, state SHALL return to FILL at that edge; ROW_ADDR increments by 1, wrapping from ROWS-1 to 0.
REQ-020 FRAME_DONE SHALL be 1 for exactly the cycle after an ACK taken while ROW_ADDR=ROWS-1, else 0.
REQ-021 ROW_ACK in FILL SHALL be ignored.
REQ-022 ROW_VALID SHALL never assert without 16 bits accepted since the last FILL entry.

Reset
REQ-023 RST=1 at a rising edge SHALL force: state FILL, COL=0, ROW_ADDR=0, ROW_DATA=16'h0000, ROW_VALID=0, FRAME_DONE=0, ROW_PAR=0; BIT_READY=1 the following cycle.
REQ-024 RST SHALL take priority over BIT_VALID and ROW_ACK in the same cycle; a partially filled or held row is discarded.

Configuration
REQ-025 With macro ROW_PARITY_EN defined, ROW_PAR SHALL equal XOR of ROW_DATA[15:0], registered, valid whenever ROW_VALID=1.
REQ-026 Without ROW_PARITY_EN, no parity logic SHALL be built and ROW_PAR SHALL be constant 0.

Verification
REQ-027 Reset, then 16 accepted bits 1,0,1,0... (col0=1) -> ROW_VALID=1 one cycle after 16th accept, ROW_DATA=16'h5555, ROW_ADDR=0, COL=0.
REQ-028 In HOLD, BIT_VALID=1 for 5 cycles with ROW_ACK=0 -> BIT_READY=0, ROW_DATA stays 16'h5555; then ROW_ACK=1 -> next cycle FILL, ROW_ADDR=1.
REQ-029 ROWS=4, fill and ACK 4 rows -> FRAME_DONE high exactly one cycle after 4th ACK, ROW_ADDR=0.
REQ-030 Accept 7 bits, assert RST -> COL=0, ROW_DATA=0, ROW_VALID=0; next full row fills from column 0.
REQ-031 ROW_PARITY_EN defined, row 16'h0007 -> ROW_PAR=1; row 16'h0003 -> ROW_PAR=0; macro undefined -> ROW_PAR=0 for both.
REQ-032 BIT_VALID toggled randomly (gaps) over one row of 16'hA5C3 -> final ROW_DATA=16'hA5C3, COL advances only on accepted cycles.
